// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage.
// It raises CacheStall while a load refill or a store write beat is still in progress.
module dcache_ctrl #(
  parameter int SETS  = 64,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  ByteEnM,
  output logic [31:0] ReadDataM,
  output logic        CacheStall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

  state_t                   state;
  logic [OFF_W-1:0]         beat;
  logic [OFF_W-1:0]         next_beat;
  logic [SETS-1:0]          valid;
  logic [TAG_W-1:0]         tags [SETS];
  logic [31:0]              data [SETS*WORDS];

  logic [OFF_W-1:0]         offset;
  logic [IDX_W-1:0]         index;
  logic [TAG_W-1:0]         tag;
  logic [IDX_W+OFF_W-1:0]   word_ptr;
  logic [IDX_W+OFF_W-1:0]   fill_ptr;
  logic                     hit;
  logic                     is_load;
  logic                     is_store;
  logic                     refill_last;
  logic [31:0]              cur_word;
  logic                     unused_addr_lsb;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  assign offset          = ALUResultM[2 +: OFF_W];
  assign index           = ALUResultM[2+OFF_W +: IDX_W];
  assign tag             = ALUResultM[31 -: TAG_W];
  assign unused_addr_lsb = &{1'b0, ALUResultM[1:0]};
  assign word_ptr        = {index, offset};
  assign fill_ptr        = {index, beat};
  assign next_beat       = beat + 1'b1;
  assign hit             = valid[index] && (tags[index] == tag);
  assign is_store        = MemWriteM;
  assign is_load         = MemReadM && !MemWriteM;
  assign cur_word        = data[word_ptr];
  assign refill_last     = (state == REFILL) && mem_ready && (beat == OFF_W'(WORDS-1));

  always_comb begin
    CacheStall = 1'b0;
    ReadDataM  = '0;
    case (state)
      IDLE: begin
        CacheStall = is_store || (is_load && !hit);
        if (is_load && hit) ReadDataM = cur_word;
      end
      REFILL, WRITE: CacheStall = 1'b1;
      default:       CacheStall = 1'b0;
    endcase
  end

  // Control state and registered memory-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      valid     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_store) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {ALUResultM[31:2], 2'b00};
            mem_wdata <= WriteDataM;
            mem_be    <= ByteEnM;
          end else if (is_load && !hit) begin
            state    <= REFILL;
            beat     <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {tag, index, {OFF_W{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          if (mem_ready) begin
            beat     <= next_beat;
            mem_addr <= {tag, index, next_beat, 2'b00};
            if (refill_last) begin
              valid[index] <= 1'b1;
              state        <= IDLE;
              mem_req      <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        // DONE lets the pipeline move past the held store before IDLE looks again.
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ready) data[fill_ptr] <= mem_rdata;
    if (state == WRITE && mem_ready && hit)
      data[word_ptr] <= merge_bytes(cur_word, WriteDataM, ByteEnM);
    if (refill_last) tags[index] <= tag;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a behavioural memory with configurable latency,
// cycle-counted loads and stores, and hand-computed expected data.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  ByteEnM;
  logic [31:0] ReadDataM;
  logic        CacheStall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  dcache_ctrl #(.SETS(64), .WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .ByteEnM(ByteEnM), .ReadDataM(ReadDataM),
    .CacheStall(CacheStall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural main memory
  logic [31:0] mem [logic [31:0]];
  int          lat  = 0;
  int          wcnt = 0;
  logic [31:0] rd_q [$];
  int          wr_n = 0;
  logic [31:0] wr_addr = '0;
  logic [3:0]  wr_be = '0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    mem_ready = mem_req && !rst && (wcnt >= lat);
    mem_rdata = mem_ready ? rd(mem_addr) : 32'h0;
  end

  always @(posedge clk) begin
    if (rst) wcnt = 0;
    else if (mem_req && mem_ready) begin
      wcnt = 0;
      if (mem_we) begin
        wr_n++;
        wr_addr = mem_addr;
        wr_be   = mem_be;
        mem[mem_addr] = bmerge(rd(mem_addr), mem_wdata, mem_be);
      end else begin
        rd_q.push_back(mem_addr);
      end
    end else if (mem_req) wcnt++;
  end

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output int stalls, output logic [31:0] rdata);
    @(negedge clk);
    MemReadM   = !wr;
    MemWriteM  = wr;
    ALUResultM = a;
    WriteDataM = wd;
    ByteEnM    = be;
    rd_q.delete();
    wr_n   = 0;
    stalls = 0;
    #1;
    while (CacheStall === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (stalls >= 200) chk("stall_timeout", 32'd1, 32'd0);
    rdata = ReadDataM;
    @(negedge clk);
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
  endtask

  function automatic logic [31:0] qat(input int i);
    if (i < rd_q.size()) return rd_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  int          st;
  logic [31:0] rdv;
  int          n;

  initial begin
    rst = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
    ALUResultM = '0; WriteDataM = '0; ByteEnM = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    mem[32'h100] = 32'h11; mem[32'h104] = 32'h22;
    mem[32'h108] = 32'h33; mem[32'h10C] = 32'h44;
    #2 rst = 1'b1;
    #2;
    chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
    chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
    chk("rst_mem_addr",  mem_addr,           32'd0);
    chk("rst_mem_wdata", mem_wdata,          32'd0);
    chk("rst_mem_be",    {28'd0, mem_be},    32'd0);
    chk("rst_stall",     {31'd0, CacheStall}, 32'd0);
    chk("rst_rdata",     ReadDataM,          32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cold miss on 0x100
    access(1'b0, 32'h100, 32'h0, 4'h0, st, rdv);
    chk("miss_stalls", st, 32'd5);
    chk("miss_rdata", rdv, 32'h11);
    chk("miss_beats", rd_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("miss_beat_addr", qat(i), 32'h100 + 32'(4*i));

    // Hit on the freshly filled line
    access(1'b0, 32'h108, 32'h0, 4'h0, st, rdv);
    chk("hit_stalls", st, 32'd0);
    chk("hit_rdata", rdv, 32'h33);
    chk("hit_no_beats", rd_q.size(), 32'd0);
    chk("hit_mem_req", {31'd0, mem_req}, 32'd0);

    // Partial store hit, then load the merged word
    access(1'b1, 32'h104, 32'hAABB_CCDD, 4'b0011, st, rdv);
    chk("st_hit_stalls", st, 32'd2);
    chk("st_hit_beats", wr_n, 32'd1);
    chk("st_hit_addr", wr_addr, 32'h104);
    chk("st_hit_be", {28'd0, wr_be}, 32'h3);
    access(1'b0, 32'h104, 32'h0, 4'h0, st, rdv);
    chk("ld_merged_stalls", st, 32'd0);
    chk("ld_merged_rdata", rdv, 32'h0000_CCDD);

    // Back-to-back stores keep the same per-store stall
    access(1'b1, 32'h108, 32'h0000_0055, 4'b0001, st, rdv);
    chk("st_b2b0_stalls", st, 32'd2);
    access(1'b1, 32'h10C, 32'h6600_0000, 4'b1000, st, rdv);
    chk("st_b2b1_stalls", st, 32'd2);
    access(1'b0, 32'h10C, 32'h0, 4'h0, st, rdv);
    chk("ld_b2b_rdata", rdv, 32'h6600_0044);

    // Store miss does not allocate
    access(1'b1, 32'h2000, 32'h1234_5678, 4'b1111, st, rdv);
    chk("st_miss_stalls", st, 32'd2);
    chk("st_miss_beats", wr_n, 32'd1);
    access(1'b0, 32'h2000, 32'h0, 4'h0, st, rdv);
    chk("noalloc_stalls", st, 32'd5);
    chk("noalloc_rdata", rdv, 32'h1234_5678);
    chk("noalloc_beats", rd_q.size(), 32'd4);

    // Conflict miss: 0x1100 shares the index of 0x100
    access(1'b0, 32'h1100, 32'h0, 4'h0, st, rdv);
    chk("conf_stalls", st, 32'd5);
    chk("conf_first_addr", qat(0), 32'h1100);
    chk("conf_rdata", rdv, 32'hA5A5_1100);
    access(1'b0, 32'h100, 32'h0, 4'h0, st, rdv);
    chk("reload_stalls", st, 32'd5);
    chk("reload_rdata", rdv, 32'h11);

    // Reset during a slow refill, after two beats have landed
    lat = 3;
    @(negedge clk);
    rd_q.delete();
    MemReadM = 1'b1; ALUResultM = 32'h3100;
    n = 0;
    while (rd_q.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached", {31'd0, (rd_q.size() >= 2)}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    MemReadM = 1'b0;
    #1;
    chk("rst_mid_stall", {31'd0, CacheStall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, 32'h100, 32'h0, 4'h0, st, rdv);
    chk("post_rst_stalls", st, 32'd17);
    chk("post_rst_beats", rd_q.size(), 32'd4);
    chk("post_rst_rdata", rdv, 32'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
